// File: rtl/bt_pipe_out_source.sv
// Block-throttled pattern source feeding an okBTPipeOut endpoint through a first-word-fall-through FIFO.
// Optional statistics counters are built when BT_PIPE_OUT_SOURCE_STATS_EN is defined.
module bt_pipe_out_source #(
    parameter int BLOCK_WORDS = 256,
    parameter int FIFO_AW     = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  pattern,
    input  logic [31:0] seed,
    input  logic        throttle_set,
    input  logic [31:0] throttle_val,
    input  logic        ep_read,
    input  logic        ep_blockstrobe,
    output logic [31:0] ep_datain,
    output logic        ep_ready,
    output logic        underrun,
    output logic [31:0] words_sent,
    output logic [15:0] blocks_sent
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_ZERO  = {(FIFO_AW+1){1'b0}};
    localparam logic [FIFO_AW:0]   CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_BLOCK = (FIFO_AW+1)'(BLOCK_WORDS);
    localparam logic [FIFO_AW-1:0] PTR_ZERO  = {FIFO_AW{1'b0}};
    localparam logic [FIFO_AW-1:0] PTR_ONE   = {{(FIFO_AW-1){1'b0}}, 1'b1};

    // Next generator word; unused selects fall back to the counter.
    function automatic logic [31:0] gen_next(input logic [2:0] sel, input logic [31:0] g);
        logic [31:0] n;
        case (sel)
            3'd0:    n = g + 32'd1;
            3'd1:    n = {g[30:0], g[31] ^ g[21] ^ g[1] ^ g[0]};
            3'd2:    n = {g[30:0], g[31]};
            3'd3:    n = g;
            3'd4:    n = ~g;
            default: n = g + 32'd1;
        endcase
        return n;
    endfunction

    logic [31:0]        mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
    logic [FIFO_AW:0]   count_r, count_after_pop_s, count_next_s;
    logic [31:0]        g_r, t_r, head_next_s, head_r;
    logic [2:0]         pattern_r;
    logic               push_s, pop_s, empty_s, full_s;
    logic               ready_r, underrun_r;

    // FIFO bookkeeping and the value the head register will hold after this edge.
    always_comb begin
        empty_s           = (count_r == CNT_ZERO);
        full_s            = (count_r == CNT_FULL);
        push_s            = t_r[31] && !full_s;
        pop_s             = ep_read && !empty_s;
        rd_ptr_next_s     = rd_ptr_r;
        count_after_pop_s = count_r;
        head_next_s       = 32'd0;
        if (pop_s) begin
            rd_ptr_next_s     = rd_ptr_r + PTR_ONE;
            count_after_pop_s = count_r - CNT_ONE;
        end else begin
            rd_ptr_next_s     = rd_ptr_r;
            count_after_pop_s = count_r;
        end
        if (push_s) begin
            count_next_s = count_after_pop_s + CNT_ONE;
        end else begin
            count_next_s = count_after_pop_s;
        end
        // A word pushed into an otherwise empty FIFO bypasses the array to become the head.
        if (count_next_s == CNT_ZERO) begin
            head_next_s = 32'd0;
        end else if (push_s && (count_after_pop_s == CNT_ZERO)) begin
            head_next_s = g_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage array; contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= g_r;
        end
    end

    // Pointers, count, generator, throttle and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            head_r     <= 32'd0;
            ready_r    <= 1'b0;
            underrun_r <= 1'b0;
            t_r        <= 32'hFFFF_FFFF;
            pattern_r  <= pattern;
            if ((seed == 32'd0) && ((pattern == 3'd1) || (pattern == 3'd2))) begin
                g_r <= 32'd1;
            end else begin
                g_r <= seed;
            end
        end else begin
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
            ready_r  <= (count_r >= CNT_BLOCK);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                g_r      <= gen_next(pattern_r, g_r);
            end
            if (ep_read && empty_s) begin
                underrun_r <= 1'b1;
            end
            if (throttle_set) begin
                t_r <= throttle_val;
            end else begin
                t_r <= {t_r[30:0], t_r[31]};
            end
        end
    end

    assign ep_datain = head_r;
    assign ep_ready  = ready_r;
    assign underrun  = underrun_r;

`ifdef BT_PIPE_OUT_SOURCE_STATS_EN
    logic [31:0] words_r;
    logic [15:0] blocks_r;

    // Free-running pop and block counters, wrapping at full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_r  <= 32'd0;
            blocks_r <= 16'd0;
        end else begin
            if (pop_s) begin
                words_r <= words_r + 32'd1;
            end
            if (ep_blockstrobe) begin
                blocks_r <= blocks_r + 16'd1;
            end
        end
    end

    assign words_sent  = words_r;
    assign blocks_sent = blocks_r;
`else
    logic unused_blockstrobe_s;
    assign unused_blockstrobe_s = ep_blockstrobe;
    assign words_sent  = 32'd0;
    assign blocks_sent = 16'd0;
`endif

endmodule
